// File: rtl/quad_sort_pkg.sv
// ----------------------------------------------------------------------------
// quad_sort_pkg
//   Shared definitions for the quad sort sequencer and its companion selector.
//   - state_e      : sequencer FSM states (COLLECT, FETCH, EMIT)
//   - GROUP_SIZE   : number of buffer slots presented to the selector
//   - pad_value()  : all-ones word used to fill unused slots so they sort last
//                    (returned at the widest supported size; callers cast it
//                    down to their own MAX_NUM_SIZE, which must be <= 64)
// ----------------------------------------------------------------------------
package quad_sort_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        FETCH   = 2'd1,
        EMIT    = 2'd2
    } state_e;

    localparam int GROUP_SIZE    = 4;
    localparam int PAD_WIDTH_MAX = 64;

    function automatic logic [PAD_WIDTH_MAX-1:0] pad_value();
        return '1;
    endfunction

endpackage

// File: rtl/nth_smallest.sv
// ----------------------------------------------------------------------------
// nth_smallest
//   Shared combinational 4-way order-statistic selector. Returns the value of
//   rank index_in (0 = smallest) among numbers_in, comparing unsigned. Equal
//   values are ranked by slot position (lower slot first).
//   Ports:
//     numbers_in [3:0] : four candidate values
//     index_in         : requested rank
//     valid_in         : request valid
//     min_out          : value at the requested rank
//     valid_out        : result valid (follows valid_in)
// ----------------------------------------------------------------------------
module nth_smallest #(
    parameter int MAX_NUM_SIZE = 32
) (
    input  logic [3:0][MAX_NUM_SIZE-1:0] numbers_in,
    input  logic [1:0]                   index_in,
    input  logic                         valid_in,
    output logic [MAX_NUM_SIZE-1:0]      min_out,
    output logic                         valid_out
);

    logic [2:0] rank_of [4];

    // Each slot's rank is the count of slots that sort strictly ahead of it;
    // the slot-position tie-break makes the four ranks a permutation of 0..3.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rank_of[i] = '0;
            for (int j = 0; j < 4; j++) begin
                if ((j != i) &&
                    ((numbers_in[j] < numbers_in[i]) ||
                     ((numbers_in[j] == numbers_in[i]) && (j < i)))) begin
                    rank_of[i] = rank_of[i] + 3'd1;
                end
            end
        end
    end

    always_comb begin
        min_out = '0;
        for (int i = 0; i < 4; i++) begin
            if (rank_of[i] == {1'b0, index_in}) begin
                min_out = numbers_in[i];
            end
        end
    end

    assign valid_out = valid_in;

endmodule

// File: rtl/quad_sort_sequencer.sv
// ----------------------------------------------------------------------------
// quad_sort_sequencer
//   Buffers a group of 1..4 values from a valid/ready stream, presents the
//   group to an external nth_smallest selector, sweeps rank 0..count-1 and
//   streams the values out in ascending (unsigned) order with a last flag.
//   Ports:
//     clk_in, rst_in                       : clock, synchronous active-high reset
//     data_in/data_valid_in/data_last_in   : input stream (last closes a group)
//     data_ready_out                       : input accepted this cycle (COLLECT)
//     sel_numbers_out/sel_valid_out/
//     sel_index_out                        : request to the selector
//     sel_min_in/sel_valid_in              : combinational selector response
//     sorted_out/sorted_rank_out/
//     sorted_last_out/sorted_valid_out     : sorted output stream
//     sorted_ready_in                      : consumer accepts
// ----------------------------------------------------------------------------
module quad_sort_sequencer
    import quad_sort_pkg::*;
#(
    parameter int MAX_NUM_SIZE = 32
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [MAX_NUM_SIZE-1:0]      data_in,
    input  logic                         data_valid_in,
    input  logic                         data_last_in,
    output logic                         data_ready_out,
    output logic [3:0][MAX_NUM_SIZE-1:0] sel_numbers_out,
    output logic                         sel_valid_out,
    output logic [1:0]                   sel_index_out,
    input  logic [MAX_NUM_SIZE-1:0]      sel_min_in,
    input  logic                         sel_valid_in,
    output logic [MAX_NUM_SIZE-1:0]      sorted_out,
    output logic [1:0]                   sorted_rank_out,
    output logic                         sorted_last_out,
    output logic                         sorted_valid_out,
    input  logic                         sorted_ready_in
);

    localparam logic [MAX_NUM_SIZE-1:0] PAD = MAX_NUM_SIZE'(pad_value());

    state_e                              state_q, state_d;
    logic   [2:0]                        count_q, count_d;
    logic   [1:0]                        idx_q, idx_d;
    logic   [GROUP_SIZE-1:0][MAX_NUM_SIZE-1:0] buffer_q, buffer_d;
    logic   [MAX_NUM_SIZE-1:0]           out_q, out_d;
    logic   [1:0]                        rank_q, rank_d;
    logic                                last_q, last_d;

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d          = state_q;
        count_d          = count_q;
        idx_d            = idx_q;
        buffer_d         = buffer_q;
        out_d            = out_q;
        rank_d           = rank_q;
        last_d           = last_q;
        data_ready_out   = 1'b0;
        sel_valid_out    = 1'b0;
        sorted_valid_out = 1'b0;

        case (state_q)
            COLLECT: begin
                data_ready_out = 1'b1;
                if (data_valid_in) begin
                    buffer_d[count_q[1:0]] = data_in;
                    count_d                = count_q + 3'd1;
                    if ((count_q == 3'd3) || data_last_in) begin
                        state_d = FETCH;
                        idx_d   = '0;
                        // Unused slots hold all-ones so they rank after every
                        // real value and are never reached by the sweep.
                        for (int i = 0; i < GROUP_SIZE; i++) begin
                            if (i > int'(count_q)) begin
                                buffer_d[i] = PAD;
                            end
                        end
                    end
                end
            end

            FETCH: begin
                sel_valid_out = 1'b1;
                // A missing selector response is retried rather than emitted.
                if (sel_valid_in) begin
                    out_d   = sel_min_in;
                    rank_d  = idx_q;
                    last_d  = ({1'b0, idx_q} == (count_q - 3'd1));
                    state_d = EMIT;
                end
            end

            EMIT: begin
                sorted_valid_out = 1'b1;
                if (sorted_ready_in) begin
                    if (last_q) begin
                        state_d  = COLLECT;
                        count_d  = '0;
                        idx_d    = '0;
                        buffer_d = {GROUP_SIZE{PAD}};
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = FETCH;
                    end
                end
            end

            default: state_d = COLLECT;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values, independent of statement order. The buffer is a handful
    // of flops (not a RAM), so it is reset explicitly to the padding value.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= COLLECT;
            count_q  <= '0;
            idx_q    <= '0;
            buffer_q <= {GROUP_SIZE{PAD}};
            out_q    <= '0;
            rank_q   <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            buffer_q <= buffer_d;
            out_q    <= out_d;
            rank_q   <= rank_d;
            last_q   <= last_d;
        end
    end

    // The group is only shown to the selector once it is complete; it cannot
    // change outside COLLECT, so it is stable for the whole sweep.
    assign sel_numbers_out = (state_q == COLLECT) ? '0 : buffer_q;
    assign sel_index_out   = idx_q;
    assign sorted_out      = out_q;
    assign sorted_rank_out = rank_q;
    assign sorted_last_out = last_q;

endmodule

// File: tb/tb_quad_sort_sequencer.sv
module tb_quad_sort_sequencer;

    localparam int W = 32;

    logic                clk;
    logic                rst_in;
    logic [W-1:0]        data_in;
    logic                data_valid_in;
    logic                data_last_in;
    logic                data_ready_out;
    logic [3:0][W-1:0]   sel_numbers;
    logic                sel_valid;
    logic [1:0]          sel_index;
    logic [W-1:0]        sel_min;
    logic                sel_valid_raw;
    logic                sel_block;
    logic                sel_valid_back;
    logic [W-1:0]        sorted_out;
    logic [1:0]          sorted_rank_out;
    logic                sorted_last_out;
    logic                sorted_valid_out;
    logic                sorted_ready_in;

    int checks   = 0;
    int failures = 0;

    quad_sort_sequencer #(.MAX_NUM_SIZE(W)) dut (
        .clk_in          (clk),
        .rst_in          (rst_in),
        .data_in         (data_in),
        .data_valid_in   (data_valid_in),
        .data_last_in    (data_last_in),
        .data_ready_out  (data_ready_out),
        .sel_numbers_out (sel_numbers),
        .sel_valid_out   (sel_valid),
        .sel_index_out   (sel_index),
        .sel_min_in      (sel_min),
        .sel_valid_in    (sel_valid_back),
        .sorted_out      (sorted_out),
        .sorted_rank_out (sorted_rank_out),
        .sorted_last_out (sorted_last_out),
        .sorted_valid_out(sorted_valid_out),
        .sorted_ready_in (sorted_ready_in)
    );

    nth_smallest #(.MAX_NUM_SIZE(W)) u_sel (
        .numbers_in(sel_numbers),
        .index_in  (sel_index),
        .valid_in  (sel_valid),
        .min_out   (sel_min),
        .valid_out (sel_valid_raw)
    );

    // Lets a test withhold the selector response to exercise the retry path.
    assign sel_valid_back = sel_valid_raw & ~sel_block;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] d, input logic last, output bit timeout);
        data_in       = d;
        data_last_in  = last;
        data_valid_in = 1'b1;
        timeout       = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (data_ready_out) begin
                step();
                timeout = 1'b0;
                break;
            end
            step();
        end
        data_valid_in = 1'b0;
        data_last_in  = 1'b0;
    endtask

    task automatic send_group(input logic [W-1:0] vals [4], input int n, output bit timeout);
        bit t;
        timeout = 1'b0;
        for (int k = 0; k < n; k++) begin
            send_word(vals[k], (k == n - 1), t);
            timeout = timeout | t;
        end
    endtask

    // Waits for a valid output, captures it and lets the handshake edge pass.
    task automatic recv(output logic [W-1:0] v, output logic [1:0] r, output logic l,
                        output bit timeout, output int waited);
        v = '0; r = '0; l = 1'b0;
        waited  = 0;
        timeout = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (sorted_valid_out) begin
                v = sorted_out; r = sorted_rank_out; l = sorted_last_out;
                timeout = 1'b0;
                step();
                break;
            end
            step();
            waited++;
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        step();
        step();
        rst_in = 1'b0;
        checks++; if (data_ready_out !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", data_ready_out); end
        checks++; if (sorted_valid_out !== 1'b0) begin failures++; $display("FAIL reset_sorted_valid got=%b want=0", sorted_valid_out); end
        checks++; if (sorted_out !== '0) begin failures++; $display("FAIL reset_sorted_out got=%0h want=0", sorted_out); end
        checks++; if (sel_valid !== 1'b0) begin failures++; $display("FAIL reset_sel_valid got=%b want=0", sel_valid); end
        checks++; if (sel_numbers !== '0) begin failures++; $display("FAIL reset_sel_numbers got=%0h want=0", sel_numbers); end
        checks++; if ({sorted_rank_out, sorted_last_out, sel_index} !== 5'b0) begin failures++; $display("FAIL reset_rank_last_index got=%b want=00000", {sorted_rank_out, sorted_last_out, sel_index}); end
    endtask

    task automatic test_full_group();
        logic [W-1:0] in_v  [4] = '{32'd40, 32'd7, 32'd19, 32'd7};
        logic [W-1:0] exp_v [4] = '{32'd7, 32'd7, 32'd19, 32'd40};
        logic [W-1:0] v; logic [1:0] r; logic l; bit to; int w;
        send_group(in_v, 4, to);
        checks++; if (to) begin failures++; $display("FAIL full_send_timeout got=1 want=0"); end
        for (int k = 0; k < 4; k++) begin
            recv(v, r, l, to, w);
            checks++; if (to || v !== exp_v[k]) begin failures++; $display("FAIL full_value[%0d] got=%0d want=%0d timeout=%0d", k, v, exp_v[k], to); end
            checks++; if (r !== 2'(k)) begin failures++; $display("FAIL full_rank[%0d] got=%0d want=%0d", k, r, k); end
            checks++; if (l !== (k == 3)) begin failures++; $display("FAIL full_last[%0d] got=%b want=%b", k, l, (k == 3)); end
            // One FETCH cycle precedes every EMIT: 2 cycles after the accept,
            // then one word every other cycle.
            checks++; if (w !== 1) begin failures++; $display("FAIL full_spacing[%0d] got=%0d want=1", k, w); end
        end
    endtask

    task automatic test_short_group();
        logic [W-1:0] in_v  [4] = '{32'd300, 32'd5, 32'd0, 32'd0};
        logic [W-1:0] exp_v [2] = '{32'd5, 32'd300};
        logic [W-1:0] v; logic [1:0] r; logic l; bit to; int w;
        // A last flag with no valid word must not close a group.
        data_last_in = 1'b1;
        step();
        data_last_in = 1'b0;
        send_group(in_v, 2, to);
        checks++; if (to) begin failures++; $display("FAIL short_send_timeout got=1 want=0"); end
        for (int k = 0; k < 2; k++) begin
            recv(v, r, l, to, w);
            checks++; if (to || v !== exp_v[k]) begin failures++; $display("FAIL short_value[%0d] got=%0d want=%0d timeout=%0d", k, v, exp_v[k], to); end
            checks++; if (r !== 2'(k) || l !== (k == 1)) begin failures++; $display("FAIL short_rank_last[%0d] got=%0d/%b want=%0d/%b", k, r, l, k, (k == 1)); end
        end
        for (int i = 0; i < 4; i++) begin
            checks++; if (sorted_valid_out !== 1'b0 || data_ready_out !== 1'b1) begin failures++; $display("FAIL short_no_padding[%0d] valid got=%b want=0 ready got=%b want=1", i, sorted_valid_out, data_ready_out); end
            step();
        end
    endtask

    task automatic test_single_max();
        logic [W-1:0] v; logic [1:0] r; logic l; bit to; int w;
        send_word(32'hFFFF_FFFF, 1'b1, to);
        checks++; if (to) begin failures++; $display("FAIL max_send_timeout got=1 want=0"); end
        recv(v, r, l, to, w);
        checks++; if (to || v !== 32'hFFFF_FFFF) begin failures++; $display("FAIL max_value got=%0h want=ffffffff timeout=%0d", v, to); end
        checks++; if (r !== 2'd0 || l !== 1'b1) begin failures++; $display("FAIL max_rank_last got=%0d/%b want=0/1", r, l); end
        step();
        checks++; if (sorted_valid_out !== 1'b0) begin failures++; $display("FAIL max_extra_output got=%b want=0", sorted_valid_out); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] in_v  [4] = '{32'd4, 32'd3, 32'd2, 32'd1};
        logic [W-1:0] v; logic [1:0] r; logic l; bit to; int w;
        send_group(in_v, 4, to);
        checks++; if (to) begin failures++; $display("FAIL bp_send_timeout got=1 want=0"); end
        checks++; if (data_ready_out !== 1'b0) begin failures++; $display("FAIL bp_ready_fetch got=%b want=0", data_ready_out); end
        recv(v, r, l, to, w);
        checks++; if (to || v !== 32'd1) begin failures++; $display("FAIL bp_value0 got=%0d want=1 timeout=%0d", v, to); end
        sorted_ready_in = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            checks++; if (sorted_valid_out !== 1'b1 || sorted_out !== 32'd2 || sorted_rank_out !== 2'd1) begin failures++; $display("FAIL bp_hold[%0d] valid/value/rank got=%b/%0d/%0d want=1/2/1", i, sorted_valid_out, sorted_out, sorted_rank_out); end
            checks++; if (data_ready_out !== 1'b0) begin failures++; $display("FAIL bp_stall_ready[%0d] got=%b want=0", i, data_ready_out); end
            step();
        end
        sorted_ready_in = 1'b1;
        for (int k = 1; k < 4; k++) begin
            recv(v, r, l, to, w);
            checks++; if (to || v !== W'(k + 1) || r !== 2'(k) || l !== (k == 3)) begin failures++; $display("FAIL bp_value[%0d] got=%0d/%0d/%b want=%0d/%0d/%b timeout=%0d", k, v, r, l, k + 1, k, (k == 3), to); end
        end
    endtask

    task automatic test_reset_mid_op();
        logic [W-1:0] in_v  [4] = '{32'd5, 32'd6, 32'd7, 32'd8};
        logic [W-1:0] grp2  [4] = '{32'd9, 32'd8, 32'd0, 32'd0};
        logic [W-1:0] v; logic [1:0] r; logic l; bit to; int w;
        bit seen;
        send_group(in_v, 4, to);
        recv(v, r, l, to, w);
        checks++; if (to || v !== 32'd5) begin failures++; $display("FAIL rst_pre_value got=%0d want=5 timeout=%0d", v, to); end
        sorted_ready_in = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (sorted_valid_out) begin seen = 1'b1; break; end
            step();
        end
        checks++; if (!seen || sorted_rank_out !== 2'd1) begin failures++; $display("FAIL rst_emit_rank1 got=%0d seen=%0d want=1", sorted_rank_out, seen); end
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        checks++; if (data_ready_out !== 1'b1 || sorted_valid_out !== 1'b0 || sel_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_handshake got=%b%b%b want=100", data_ready_out, sorted_valid_out, sel_valid); end
        checks++; if (sorted_out !== '0 || {sorted_rank_out, sorted_last_out, sel_index} !== 5'b0 || sel_numbers !== '0) begin failures++; $display("FAIL rst_mid_outputs got=%0h/%b want=0/00000", sorted_out, {sorted_rank_out, sorted_last_out, sel_index}); end
        sorted_ready_in = 1'b1;
        send_group(grp2, 2, to);
        for (int k = 0; k < 2; k++) begin
            recv(v, r, l, to, w);
            checks++; if (to || v !== W'(8 + k) || r !== 2'(k) || l !== (k == 1)) begin failures++; $display("FAIL rst_new_group[%0d] got=%0d/%0d/%b want=%0d/%0d/%b timeout=%0d", k, v, r, l, 8 + k, k, (k == 1), to); end
        end
        step();
        checks++; if (sorted_valid_out !== 1'b0) begin failures++; $display("FAIL rst_stale_output got=%b want=0", sorted_valid_out); end
    endtask

    task automatic test_protocol_retry();
        logic [W-1:0] v; logic [1:0] r; logic l; bit to; int w;
        sel_block = 1'b1;
        send_word(32'd77, 1'b1, to);
        for (int i = 0; i < 3; i++) begin
            checks++; if (sorted_valid_out !== 1'b0 || sel_valid !== 1'b1) begin failures++; $display("FAIL retry_hold[%0d] valid/sel got=%b/%b want=0/1", i, sorted_valid_out, sel_valid); end
            step();
        end
        sel_block = 1'b0;
        recv(v, r, l, to, w);
        checks++; if (to || v !== 32'd77 || r !== 2'd0 || l !== 1'b1) begin failures++; $display("FAIL retry_value got=%0d/%0d/%b want=77/0/1 timeout=%0d", v, r, l, to); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] grp_a [4] = '{32'd10, 32'd20, 32'd0, 32'd0};
        logic [W-1:0] grp_b [4] = '{32'd3, 32'd1, 32'd2, 32'd0};
        logic [W-1:0] v; logic [1:0] r; logic l; bit to; int w;
        send_group(grp_a, 2, to);
        for (int k = 0; k < 2; k++) begin
            recv(v, r, l, to, w);
            checks++; if (to || v !== W'(10 * (k + 1)) || l !== (k == 1)) begin failures++; $display("FAIL b2b_a[%0d] got=%0d/%b want=%0d/%b timeout=%0d", k, v, l, 10 * (k + 1), (k == 1), to); end
        end
        checks++; if (data_ready_out !== 1'b1) begin failures++; $display("FAIL b2b_ready_after_last got=%b want=1", data_ready_out); end
        send_group(grp_b, 4, to);
        checks++; if (to) begin failures++; $display("FAIL b2b_send_timeout got=1 want=0"); end
        for (int k = 0; k < 4; k++) begin
            recv(v, r, l, to, w);
            checks++; if (to || v !== W'(k) || r !== 2'(k) || l !== (k == 3)) begin failures++; $display("FAIL b2b_b[%0d] got=%0d/%0d/%b want=%0d/%0d/%b timeout=%0d", k, v, r, l, k, k, (k == 3), to); end
        end
    endtask

    initial begin
        rst_in          = 1'b1;
        data_in         = '0;
        data_valid_in   = 1'b0;
        data_last_in    = 1'b0;
        sorted_ready_in = 1'b1;
        sel_block       = 1'b0;
        test_reset();
        test_full_group();
        test_short_group();
        test_single_max();
        test_backpressure();
        test_reset_mid_op();
        test_protocol_retry();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/quad_sort_sequencer.md
Name: quad_sort_sequencer

Overview:
- Upstream/downstream companion to the shared combinational 4-way order-statistic selector (nth_smallest).
- Collects up to 4 candidate values from a serial valid/ready stream, for example per-edge collision times of one object.
- Drives the selector with the buffered group, sweeps the rank index 0..N-1, and emits the values in ascending order on a valid/ready output stream with a last flag.
- Lets physics-update logic consume the earliest events first.

Parameters:
- MAX_NUM_SIZE, 32, bit width of every value.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-high reset
- data_in  input  MAX_NUM_SIZE  candidate value
- data_valid_in  input  1  data_in valid
- data_last_in  input  1  marks final value of a group (groups of 1..4)
- data_ready_out  output  1  block accepts data this cycle
- sel_numbers_out  output  MAX_NUM_SIZE x4 ([3:0])  buffered group to selector
- sel_valid_out  output  1  selector request valid
- sel_index_out  output  2  rank requested from selector
- sel_min_in  input  MAX_NUM_SIZE  selector result, combinational same cycle
- sel_valid_in  input  1  selector result valid
- sorted_out  output  MAX_NUM_SIZE  sorted value
- sorted_rank_out  output  2  rank of sorted_out
- sorted_last_out  output  1  final value of group
- sorted_valid_out  output  1  sorted_out valid
- sorted_ready_in  input  1  consumer accepts

Behaviour:
- Clock and reset: single clock clk_in; reset rst_in is synchronous and active-high.
- Reset (applies mid-operation too): state COLLECT, count=0, idx=0, buffer all-ones, every output 0 except data_ready_out=1. Any partial group is discarded; the next accepted word is rank-slot 0 of a new group.
- COLLECT:
  - data_ready_out=1, sel_valid_out=0, sorted_valid_out=0.
  - On data_valid_in: buffer[count] <= data_in, count++.
  - Transition to FETCH with idx=0 when the 4th word is accepted, or any word is accepted with data_last_in=1.
  - On that transition, unfilled slots are loaded with all-ones, so padding sorts last.
  - data_last_in without data_valid_in is ignored.
- FETCH (1 cycle):
  - sel_valid_out=1, sel_index_out=idx, sel_numbers_out=buffer. sel_numbers_out is held stable outside COLLECT.
  - Capture sel_min_in into the output register.
  - rank=idx; last=(idx==count-1).
  - Go to EMIT.
  - If sel_valid_in=0 (protocol error), stay in FETCH and retry.
- EMIT:
  - sorted_valid_out=1; sorted_out, rank and last are held constant until the handshake.
  - On sorted_ready_in: if last, go to COLLECT, count=0, buffer reset to all-ones; else idx++ and go to FETCH.
- Timing:
  - Latency from the closing accept to the first sorted_valid_out: 2 cycles.
  - Throughput: 1 word per 2 cycles while the consumer is ready.
  - Input is stalled (data_ready_out=0) in FETCH and EMIT.
- Output count: exactly count words are emitted, never padding. A genuine all-ones input value is still emitted, and ties keep the selector's ordering.
- Comparisons are unsigned, as in the selector.
- sel_valid_out is 0 in COLLECT and EMIT.

Decomposition:
- Package quad_sort_pkg:
  - state enum {COLLECT, FETCH, EMIT}
  - GROUP_SIZE=4 constant
  - PAD value function returning all-ones of MAX_NUM_SIZE
- No sub-module inside this block. The bench instantiates nth_smallest alongside the DUT, wired sel_* to its ports.

Test Plan:
- Full group: send 40, 7, 19, 7 (last on 4th), sorted_ready_in held 1 -> outputs 7, 7, 19, 40 with ranks 0..3, last only on 40. First valid 2 cycles after the 4th accept; valid every other cycle.
- Short group: send 300 then 5 with last -> exactly 2 outputs, 5 then 300, last on 300. No all-ones word appears.
- Single with max value: send 0xFFFFFFFF with last -> one output 0xFFFFFFFF, rank 0, last=1.
- Backpressure: full group 4, 3, 2, 1 with sorted_ready_in low for 5 cycles at rank 1:
  - sorted_out stays 2 with valid high throughout the stall;
  - data_ready_out stays 0;
  - completes as 1, 2, 3, 4.
- Reset mid-operation: assert rst_in during EMIT of rank 1 -> next cycle all outputs are at reset values and data_ready_out=1. A new group of 9, 8 with last yields 8, 9 only.
- Back-to-back groups: group A = 10, 20 (last); group B = 3, 1, 2, 0 sent immediately after A's last handshake:
  - data_ready_out returns to 1 the cycle after A's last handshake;
  - outputs are 10, 20 | 0, 1, 2, 3 with correct last flags.
